// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared types and helpers for the digit-serial magnitude
//               comparator: FSM state enum, one-hot result encoding
//               {eq, gr, less}, and a WIDTH/DIGIT legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result vector ordered {eq, gr, less}; all-zero only before the first
    // completed operation.
    typedef logic [2:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_EQ   = 3'b100;
    localparam res_t RES_GR   = 3'b010;
    localparam res_t RES_LT   = 3'b001;

    // Digit size must be 1..WIDTH and divide WIDTH evenly.
    function automatic bit width_ok(input int unsigned w, input int unsigned d);
        return (d >= 1) && (d <= w) && ((w % d) == 0);
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/digit_compare.sv
`default_nettype none
// ============================================================================
// Module      : digit_compare
// Description : Combinational DIGIT-bit unsigned magnitude compare.
// Revision    : 1.0 - initial release
// Ports       : a_i, b_i  - DIGIT-bit operands
//               eq_o      - a_i == b_i
//               gr_o      - a_i >  b_i
//               less_o    - a_i <  b_i
// ============================================================================
module digit_compare #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             eq_o,
    output logic             gr_o,
    output logic             less_o
);

    assign eq_o   = (a_i == b_i);
    assign gr_o   = (a_i >  b_i);
    assign less_o = (a_i <  b_i);

endmodule : digit_compare
`default_nettype wire

// File: rtl/mag_compare_seq.sv
`default_nettype none
// ============================================================================
// Module      : mag_compare_seq
// Description : Digit-serial magnitude comparator. Captures two WIDTH-bit
//               operands on start and compares them MSB-first, DIGIT bits per
//               clock, stopping at the first differing digit. Signed or
//               unsigned ordering is selected per operation.
// Revision    : 1.0 - initial release
// Ports       : clk           - clock, rising edge
//               rst           - synchronous active-high reset
//               start_i       - request, accepted only in IDLE
//               signed_mode_i - 1 = two's complement, 0 = unsigned
//               a_i, b_i      - operands, sampled with start_i
//               busy_o        - compare in progress
//               done_o        - one-cycle completion pulse
//               eq_o/gr_o/less_o - registered result, held until next result
//               cycles_o      - digit compares used by the last operation
// ============================================================================
module mag_compare_seq
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            signed_mode_i,
    input  logic [WIDTH-1:0]                a_i,
    input  logic [WIDTH-1:0]                b_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            eq_o,
    output logic                            gr_o,
    output logic                            less_o,
    output logic [$clog2(WIDTH/DIGIT):0]    cycles_o
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = $clog2(NDIG) + 1;

    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);
    localparam logic [CW-1:0] NDIG_CW  = CW'(NDIG);

    generate
        if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
            $error("mag_compare_seq: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    res_t               res_q, res_d;
    logic [CW-1:0]      cycles_q, cycles_d;

    logic               dig_eq;
    logic               dig_gr;
    logic               dig_less;

    // Only the top digit of the shift registers is ever compared.
    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .a_i    (sa_q[WIDTH-1 -: DIGIT]),
        .b_i    (sb_q[WIDTH-1 -: DIGIT]),
        .eq_o   (dig_eq),
        .gr_o   (dig_gr),
        .less_o (dig_less)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            res_q    <= RES_NONE;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        cycles_d = cycles_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sa_d = a_i;
                    sb_d = b_i;
                    // Flipping both sign bits maps two's-complement order
                    // onto plain unsigned order.
                    if (signed_mode_i) begin
                        sa_d[WIDTH-1] = ~a_i[WIDTH-1];
                        sb_d[WIDTH-1] = ~b_i[WIDTH-1];
                    end
                    cnt_d   = '0;
                    state_d = CMP;
                end
            end

            CMP: begin
                if (!dig_eq) begin
                    res_d    = dig_gr ? RES_GR : RES_LT;
                    cycles_d = cnt_q + CW'(1);
                    state_d  = DONE;
                end else if (cnt_q == LAST_DIG) begin
                    res_d    = RES_EQ;
                    cycles_d = NDIG_CW;
                    state_d  = DONE;
                end else begin
                    sa_d  = sa_q << DIGIT;
                    sb_d  = sb_q << DIGIT;
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o   = (state_q == CMP);
    assign done_o   = (state_q == DONE);
    assign eq_o     = res_q[2];
    assign gr_o     = res_q[1];
    assign less_o   = res_q[0];
    assign cycles_o = cycles_q;

endmodule : mag_compare_seq
`default_nettype wire

// File: doc/mag_compare_seq.md
# mag_compare_seq

Parametrised, digit-serial magnitude comparator and the successor to the fixed 4-bit combinational comparator. It captures two WIDTH-bit operands on a start pulse and compares them MSB-first, DIGIT bits per clock, stopping at the first differing digit. Registered eq/gr/less flags and a one-cycle done pulse are produced, with signed or unsigned ordering selected per operation. It sits behind any datapath that needs wide compares without a WIDTH-wide combinational carry chain.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.
- NDIG (derived), WIDTH/DIGIT: number of digits.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- signed_mode  in  1  sampled with start: 1 = two's-complement, 0 = unsigned.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; result valid and held from this cycle.
- eq  out  1  A == B.
- gr  out  1  A > B.
- less  out  1  A < B.
- cycles  out  $clog2(NDIG)+1  digit compares used by the last operation (1..NDIG).

## Operation
- States: IDLE, CMP, DONE.
- IDLE with start=1: capture a and b into shift registers sa and sb. If signed_mode=1, invert bit WIDTH-1 of both, which maps signed order onto unsigned order. Clear the digit counter, go to CMP, and set busy.
- IDLE with start=0: hold. eq, gr, less and cycles keep the last result.
- CMP: compare the top DIGIT bits of sa and sb.
  - Top digits differ: load gr/less from that compare, set eq=0, set cycles = counter+1, go to DONE.
  - Top digits equal and counter == NDIG-1: set eq=1, gr=0, less=0, set cycles = NDIG, go to DONE.
  - Otherwise: shift sa and sb left by DIGIT, increment the counter, stay in CMP.
- DONE: assert done for one cycle, clear busy, go to IDLE.
- Exactly one of eq/gr/less is 1 after any completed operation. All three are 0 only after reset, before the first completion.
- eq/gr/less/cycles update only on the CMP→DONE transition and are held until the next operation completes.
- start while busy=1 or in DONE is ignored. It is neither queued nor counted.
- start in the cycle right after the done pulse (state IDLE) is accepted normally.
- Input changes to a/b/signed_mode after acceptance have no effect.

## Timing
- Reset values: state IDLE, busy=0, done=0, eq=0, gr=0, less=0, cycles=0, counter=0.
- rst has priority over everything. Asserting it mid-operation aborts the operation with no done pulse, and all outputs take their reset values on the next edge.
- start accepted at edge T. busy is 1 from T+1. Digit compares happen at edges T+1 … T+k, where k is the index of the first differing digit (or NDIG if the operands are equal). done, with valid flags, is high during cycle T+k+1, and busy is 0 in that cycle.
- Latency: minimum 2 cycles (DIGIT = WIDTH, or MSB digit differs); maximum NDIG+1.
- Throughput: one operation per k+2 cycles when start is held high.

## Structure
- Package cmp_pkg holds:
  - the state enum (IDLE, CMP, DONE);
  - a 3-bit result encoding {eq, gr, less} with constants RES_EQ, RES_GR, RES_LT;
  - a function checking WIDTH % DIGIT == 0, used in an elaboration-time assertion.
- One sub-module: digit_compare. It is combinational, DIGIT-bit unsigned, with outputs eq/gr/less, and is instantiated once inside mag_compare_seq. The FSM, shift registers and counter live in the top module.

## Test plan
All scenarios use WIDTH=16, DIGIT=4.
- a=0x0000, b=0x0000, unsigned: start at T → done at T+5, eq=1, gr=0, less=0, cycles=4.
- a=0xA000, b=0xD000, unsigned: done at T+2, less=1, cycles=1. Repeat with a=0x1235, b=0x1234: done at T+5, gr=1, cycles=4.
- a=0x8000, b=0x0001 in both modes: signed_mode=1 gives less=1, cycles=1; signed_mode=0 gives gr=1, cycles=1. Also a=0xFFFF, b=0xFFFE signed: gr=1, cycles=4.
- Start ignored while busy: start a=0x1234, b=0x1234, then pulse start with a=0xF000, b=0x0000 at T+2. Required: a single done at T+5 with eq=1, and busy stays low in cycle T+6 unless start is asserted again.
- Reset mid-operation: start a=0x0000, b=0x0001, assert rst at T+2. Required: no done, and all outputs 0 from T+3. A new start after reset completes correctly (less=1, cycles=4).
- Back-to-back operations: hold start=1 continuously. Required: operations accepted at T, T+k+2, and so on, with flags held stable between done pulses.
